// File: rtl/vec_lane_alu_if.sv
// Handshake/operand bundle for vec_lane_alu.
// master: upstream issuer and writeback consumer. slave: the execute stage.
interface vec_lane_alu_if #(
  parameter int V = 192
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [V-1:0] a;
  logic [V-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [V-1:0] result;
  logic         busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/vec_lane_alu.sv
// Multi-cycle SIMD execute stage: V-bit operands split into W-bit lanes,
// LPC lanes computed per clock over BEATS = V/(W*LPC) beats, result handed
// off over a valid/ready handshake.
// Optional feature macro: VEC_SATURATE_EN (ADD/SUB saturate per lane).
module vec_lane_alu #(
  parameter int V   = 192,
  parameter int W   = 8,
  parameter int LPC = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  vec_lane_alu_if.slave  bus
);
  localparam int LANES = V / W;
  localparam int BEATS = LANES / LPC;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SRL
  } op_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    beat;
  logic [V-1:0]     a_q, b_q, result_q;
  op_t              op_q;
  logic [LPC*W-1:0] lane_res;
  logic             accept, last_beat;

  function automatic logic [W-1:0] lane_op(input op_t o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [W-1:0] r;
`ifdef VEC_SATURATE_EN
    logic         c;
    logic [W-1:0] s;
`endif
    r = '0;
    case (o)
`ifdef VEC_SATURATE_EN
      OP_ADD: begin
        {c, s} = {1'b0, x} + {1'b0, y};
        r = c ? '1 : s;
      end
      OP_SUB: r = (x < y) ? '0 : x - y;
`else
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
`endif
      OP_MUL: r = x * y;
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHL: r = x << y[2:0];
      OP_SRL: r = x >> y[2:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept    = (state == IDLE) && bus.in_valid && !bus.flush;
  assign last_beat = (beat == BW'(BEATS - 1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == BUSY);
  assign bus.result    = result_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state_nxt = BUSY;
        BUSY:    if (last_beat) state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Lanes belonging to the current beat, from the latched operands
  always_comb begin
    lane_res = '0;
    for (int unsigned j = 0; j < LPC; j++) begin
      lane_res[j*W +: W] = lane_op(op_q,
                                   a_q[(32'(beat) * LPC + j) * W +: W],
                                   b_q[(32'(beat) * LPC + j) * W +: W]);
    end
  end

  // Operand latch, beat counter and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
    end else if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= op_t'(bus.op);
      beat <= '0;
    end else if (bus.flush) begin
      beat <= '0;
    end else if (state == BUSY) begin
      result_q[32'(beat) * LPC * W +: LPC * W] <= lane_res;
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end
endmodule
